// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: 2-entry skid-buffered valid/ready stage that
// registers the ALU payload, resolves conditional branches and feeds forwarding.
module ex_mem_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_zero,
    input  logic [XLEN-1:0]       store_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  is_branch,
    input  logic                  branch_ne,
    input  logic [XLEN-1:0]       branch_target,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [XLEN-1:0]       out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  br_taken,
    output logic [XLEN-1:0]       br_target,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
);

    typedef struct packed {
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } payload_t;

    // EMPTY: nothing held; MAIN: M holds an item; FULL: M and S both hold items
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic logic branch_resolve(input logic br, input logic ne, input logic zero);
        return br & (zero ^ ne);
    endfunction

    occ_t           state_r;
    occ_t           state_s;
    payload_t       m_payload_r;
    payload_t       m_payload_s;
    payload_t       s_payload_r;
    payload_t       s_payload_s;
    payload_t       in_payload_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           br_taken_r;
    logic           br_taken_s;
    logic [XLEN-1:0] br_target_r;
    logic [XLEN-1:0] br_target_s;
    logic           accept_s;
    logic           xfer_s;
    logic           taken_s;

    assign in_payload_s = '{result:     alu_result,
                            store_data: store_data,
                            rd:         rd_addr,
                            reg_write:  reg_write,
                            mem_read:   mem_read,
                            mem_write:  mem_write};

    assign accept_s = in_valid & in_ready_r;
    assign xfer_s   = out_valid_r & out_ready;
    assign taken_s  = branch_resolve(is_branch, branch_ne, alu_zero);

    // Occupancy, storage and branch next-state; flush overrides everything
    always_comb begin
        state_s     = state_r;
        m_payload_s = m_payload_r;
        s_payload_s = s_payload_r;
        br_taken_s  = 1'b0;
        br_target_s = br_target_r;

        case (state_r)
            OCC_EMPTY: begin
                if (accept_s) begin
                    m_payload_s = in_payload_s;
                    state_s     = OCC_MAIN;
                end else begin
                    state_s     = OCC_EMPTY;
                end
            end
            OCC_MAIN: begin
                if (xfer_s) begin
                    if (accept_s) begin
                        m_payload_s = in_payload_s;
                        state_s     = OCC_MAIN;
                    end else begin
                        state_s     = OCC_EMPTY;
                    end
                end else if (accept_s) begin
                    s_payload_s = in_payload_s;
                    state_s     = OCC_FULL;
                end else begin
                    state_s     = OCC_MAIN;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so S can only drain into M
                if (xfer_s) begin
                    m_payload_s = s_payload_r;
                    state_s     = OCC_MAIN;
                end else begin
                    state_s     = OCC_FULL;
                end
            end
            default: begin
                state_s = OCC_EMPTY;
            end
        endcase

        if (accept_s && taken_s) begin
            br_taken_s  = 1'b1;
            br_target_s = branch_target;
        end else begin
            br_taken_s  = 1'b0;
        end

        if (flush) begin
            state_s    = OCC_EMPTY;
            br_taken_s = 1'b0;
        end else begin
            state_s    = state_s;
        end
    end

    // State, payload and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= OCC_EMPTY;
            m_payload_r <= '0;
            s_payload_r <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            br_taken_r  <= 1'b0;
            br_target_r <= {XLEN{1'b0}};
        end else begin
            state_r     <= state_s;
            m_payload_r <= m_payload_s;
            s_payload_r <= s_payload_s;
            in_ready_r  <= (state_s != OCC_FULL);
            out_valid_r <= (state_s != OCC_EMPTY);
            br_taken_r  <= br_taken_s;
            br_target_r <= br_target_s;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign out_result     = m_payload_r.result;
    assign out_store_data = m_payload_r.store_data;
    assign out_rd         = m_payload_r.rd;
    assign out_reg_write  = m_payload_r.reg_write;
    assign out_mem_read   = m_payload_r.mem_read;
    assign out_mem_write  = m_payload_r.mem_write;
    assign br_taken       = br_taken_r;
    assign br_target      = br_target_r;

    // Loads are excluded: their data only exists after the memory stage
    assign fwd_valid = out_valid_r & m_payload_r.reg_write & ~m_payload_r.mem_read
                       & (m_payload_r.rd != {REG_ADDR_W{1'b0}});
    assign fwd_rd    = m_payload_r.rd;
    assign fwd_data  = m_payload_r.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a negedge monitor scores every output
// transfer against a FIFO of accepted items; scenario tasks check timing inline.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = 32'h0;
    logic        alu_zero = 1'b0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  rd_addr = 5'd0;
    logic        reg_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_ne = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } item_t;

    item_t sb[$];
    item_t mon_exp;
    item_t mon_act;
    int    checks = 0;
    int    errors = 0;

    ex_mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .branch_ne(branch_ne), .branch_target(branch_target),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .br_taken(br_taken), .br_target(br_target),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop on output transfer, drop on flush, push on accept
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                mon_act = '{out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got result=%h rd=%0d expected no output", out_result, out_rd);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_payload got %h expected %h", mon_act, mon_exp);
                    end
                end
            end
            if (flush) sb.delete();
            if (in_valid && in_ready && !flush)
                sb.push_back('{alu_result, store_data, rd_addr, reg_write, mem_read, mem_write});
        end
    end

    always @(negedge rst_n) sb.delete();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic bne,
                         input logic zero, input logic [31:0] tgt);
        in_valid      = 1'b1;
        alu_result    = res;
        store_data    = res ^ 32'h5A5A_5A5A;
        rd_addr       = rd;
        reg_write     = rw;
        mem_read      = mr;
        mem_write     = mw;
        is_branch     = br;
        branch_ne     = bne;
        alu_zero      = zero;
        branch_target = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, br_taken, fwd_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ctrl got v/rdy/br/fwd=%b expected 0100", {out_valid, in_ready, br_taken, fwd_valid});
        end
        checks++;
        if ({out_result, out_store_data, br_target} !== 96'h0) begin
            errors++;
            $display("FAIL reset_payload got %h %h %h expected zeros", out_result, out_store_data, br_target);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(32'h0000_0010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h10) begin
            errors++;
            $display("FAIL single_out got valid=%b result=%h expected 1 00000010", out_valid, out_result);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h10) begin
            errors++;
            $display("FAIL single_fwd got %b %0d %h expected 1 5 00000010", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h1000_0000 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready item %0d got %b expected 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_bubble item %0d got out_valid=%b expected 1", i, out_valid);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stall();
        logic acc;
        int   n;
        out_ready = 1'b0;
        drive(32'hAAAA_0001, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'hAAAA_0002, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'hAAAA_0003, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hAAAA_0001) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got rdy=%b v=%b res=%h expected 0 1 aaaa0001",
                         c, in_ready, out_valid, out_result);
            end
            tick();
        end
        out_ready = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 10) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc || n != 2) begin
            errors++;
            $display("FAIL stall_release got accepted=%b after %0d cycles expected 1 after 2", acc, n);
        end
        repeat (3) tick();
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (br_taken !== 1'b1 || br_target !== 32'h100) begin
            errors++;
            $display("FAIL beq_taken got %b %h expected 1 00000100", br_taken, br_target);
        end
        tick();
        @(negedge clk);
        checks++;
        if (br_taken !== 1'b0) begin
            errors++;
            $display("FAIL beq_pulse got %b expected 0", br_taken);
        end
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0180);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (br_taken !== 1'b0) begin
            errors++;
            $display("FAIL bne_not_taken got %b expected 0", br_taken);
        end
        tick();
        out_ready = 1'b0;
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (br_taken !== 1'b1 || br_target !== 32'h200 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bne_stalled got br=%b tgt=%h v=%b expected 1 00000200 1", br_taken, br_target, out_valid);
        end
        repeat (2) tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'hF000_0001, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'hF000_0002, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, br_taken} !== 3'b010) begin
            errors++;
            $display("FAIL flush_full got v/rdy/br=%b expected 010", {out_valid, in_ready, br_taken});
        end
        tick();
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || br_taken !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got v=%b br=%b expected 0 0", out_valid, br_taken);
        end
        tick();
        drive(32'hF000_0003, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_xfer got out_valid=%b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_fwd();
        out_ready = 1'b1;
        drive(32'h0000_7777, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h0000_0BAD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_mem_read !== 1'b1 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_load got v=%b mr=%b fwd=%b expected 1 1 0", out_valid, out_mem_read, fwd_valid);
        end
        tick();
        drive(32'h0000_1234, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd0 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_rd0 got v=%b rd=%0d fwd=%b expected 1 0 0", out_valid, out_rd, fwd_valid);
        end
        tick();
        drive(32'h0000_5555, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd9 || fwd_data !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_alu got %b %0d %h expected 1 9 00001234", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_mem_write !== 1'b1 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_store got mw=%b fwd=%b expected 1 0", out_mem_write, fwd_valid);
        end
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(32'hC000_0001, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500);
        tick();
        in_valid = 1'b0;
        checks++;
        if (br_taken !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset got br=%b rdy=%b expected 1 0", br_taken, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, br_taken, fwd_valid} !== 4'b0100 || br_target !== 32'h0
            || out_result !== 32'h0 || out_rd !== 5'd0) begin
            errors++;
            $display("FAIL async_reset got v/rdy/br/fwd=%b tgt=%h res=%h rd=%0d expected 0100 0 0 0",
                     {out_valid, in_ready, br_taken, fwd_valid}, br_target, out_result, out_rd);
        end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        drive(32'hC000_0002, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_branch();
        test_flush();
        test_fwd();
        test_async_reset();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending items expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU. Captures the ALU result, zero flag, store data, destination register and memory/writeback/branch controls into a registered EX/MEM boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the stage sustains full throughput while keeping in_ready registered.
- Resolves conditional branches from the ALU zero flag and exports a forwarding path to the operand muxes that feed the ALU.

Parameters:
- XLEN, 32, datapath width (result, store data, branch target).
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream (ALU side) payload valid.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty".
- alu_result  in  XLEN  ALU result.
- alu_zero  in  1  ALU zero flag.
- store_data  in  XLEN  rs2 value for stores.
- rd_addr  in  REG_ADDR_W  destination register.
- reg_write  in  1  writeback enable.
- mem_read  in  1  load.
- mem_write  in  1  store.
- is_branch  in  1  conditional branch.
- branch_ne  in  1  0 = BEQ (taken if zero), 1 = BNE (taken if !zero).
- branch_target  in  XLEN  precomputed target PC.
- flush  in  1  kill all held entries.
- out_valid  out  1  output payload valid.
- out_ready  in  1  downstream (memory stage) accepts.
- out_result, out_store_data  out  XLEN  registered payload.
- out_rd  out  REG_ADDR_W  registered payload.
- out_reg_write, out_mem_read, out_mem_write  out  1  registered controls; each qualified by out_valid.
- br_taken  out  1  one-cycle pulse: accepted branch resolved taken.
- br_target  out  XLEN  target, valid while br_taken = 1.
- fwd_valid  out  1  out_valid & out_reg_write & !out_mem_read & (out_rd != 0).
- fwd_rd  out  REG_ADDR_W  equals out_rd.
- fwd_data  out  XLEN  equals out_result.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - out_valid = 0, skid entry empty, in_ready = 1, br_taken = 0.
  - All payload registers = 0, br_target = 0.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Payload is held stable while out_valid & !out_ready.
- Storage: main register M (drives the out_* ports) and skid register S.
  - M empty, or M transferring this cycle: an accepted item loads M. Latency = 1 cycle from accept to out_valid.
  - M full and not transferring: an accepted item loads S. in_ready falls on the next cycle.
  - M transferring and S full: S moves into M, S empties, in_ready rises next cycle.
- Ordering: strict FIFO. S is never bypassed.
- Branch resolution on accept:
  - taken = is_branch & (alu_zero ^ branch_ne).
  - br_taken is registered: asserted in the cycle after the accept, for exactly 1 cycle. br_target is captured at the same time.
  - Branch resolution does not wait for out_ready.
  - Branch items still pass through M/S with reg_write/mem_* as supplied (normally 0).
- Flush (synchronous, priority over everything):
  - Next cycle: out_valid = 0 and S empty.
  - An item offered in the flush cycle is dropped, and its branch is not resolved.
  - br_taken = 0 next cycle.
  - An out transfer occurring in the flush cycle counts as completed.
- Boundaries:
  - Simultaneous accept and output transfer with S empty: the new item replaces M. out_valid stays 1, no bubble.
  - Both M and S full: in_ready = 0. Upstream must hold its payload.
  - rd_addr = 0 never asserts fwd_valid.
  - Reset mid-stream discards all entries immediately.
- No arithmetic is performed beyond the branch XOR. All widths pass through unchanged.

Test Plan:
1. Reset then single item: alu_result = 0x0000_0010, rd = 5, reg_write = 1, out_ready = 1 -> out_valid on cycle +1; out_result = 0x10, fwd_valid = 1, fwd_rd = 5.
2. Back-to-back stream of 8 items, out_ready = 1 -> one output per cycle, in order, in_ready never drops.
3. out_ready = 0 for 3 cycles while 3 items are offered -> items 1 and 2 held (M, S), in_ready = 0 after the 2nd accept, 3rd item stalled. Release out_ready -> outputs 1, 2, 3 in order, nothing lost or duplicated.
4. BEQ with alu_zero = 1, target 0x0000_0100 -> br_taken pulse 1 cycle after accept, br_target = 0x100. BNE with alu_zero = 1 -> br_taken stays 0.
5. Flush with M and S full and a taken branch offered -> next cycle out_valid = 0, in_ready = 1, br_taken = 0.
6. Load with rd = 7 (mem_read = 1, reg_write = 1) -> fwd_valid = 0. ALU op with rd = 0 -> fwd_valid = 0. rst_n pulsed low mid-stall -> all outputs return to reset values asynchronously.
